// File: rtl/joy_db15_tx.sv
// DB15 arcade joystick serialiser: 24-bit active-low shift-out of two 12-bit player states, clocked by an async reader.
// Latency: raw pin edge to JOY_DATA is 2+FILT+1 clk cycles; no backpressure, since the reader paces the shifts.
module joy_db15_tx #(
    parameter int unsigned FILT = 3,
    parameter int unsigned TMO  = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [4:0]  bit_idx
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // index 0 = JOY_CLK, index 1 = JOY_LOAD
    logic [1:0]       pins;
    logic [1:0]       s1_q, s2_q, filt_q, filt_d, fprev_q;
    logic [1:0][3:0]  fcnt_q, fcnt_d;

    state_t           state_q, state_d;
    logic [23:0]      sreg_q, sreg_d;
    logic [4:0]       bidx_q, bidx_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             data_q, data_d;
    logic             done_q, done_d;
    logic             load_low, clk_rise;

    assign pins = {JOY_LOAD, JOY_CLK};

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (s2_q[k] != filt_q[k]) begin
                if (fcnt_q[k] == 4'(FILT - 1)) begin
                    filt_d[k] = ~filt_q[k];
                end else begin
                    fcnt_d[k] = fcnt_q[k] + 4'd1;
                end
            end
        end
    end

    assign load_low = ~filt_q[1];
    assign clk_rise = filt_q[0] & ~fprev_q[0];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bidx_d  = bidx_q;
        tmo_d   = '0;
        done_d  = 1'b0;
        // A low LOAD pre-empts everything, including a coincident clock edge.
        if (load_low) begin
            state_d = LOAD;
            sreg_d  = {~joystick2, ~joystick1};
            bidx_d  = '0;
        end else begin
            case (state_q)
                IDLE: bidx_d = '0;
                LOAD: begin
                    state_d = SHIFT;
                    bidx_d  = '0;
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sreg_d = {1'b1, sreg_q[23:1]};
                        bidx_d = bidx_q + 5'd1;
                        if (bidx_q == 5'd23) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else if (tmo_q == 16'(TMO - 1)) begin
                        state_d = IDLE;
                        bidx_d  = '0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                DONE: bidx_d = 5'd24;
                default: state_d = IDLE;
            endcase
        end
        data_d = ((state_d == LOAD) || (state_d == SHIFT)) ? sreg_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '1;
            s2_q    <= '1;
            filt_q  <= '1;
            fprev_q <= '1;
            fcnt_q  <= '0;
            state_q <= IDLE;
            sreg_q  <= '1;
            bidx_q  <= '0;
            tmo_q   <= '0;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            s1_q    <= pins;
            s2_q    <= s1_q;
            filt_q  <= filt_d;
            fprev_q <= filt_q;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bidx_q  <= bidx_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign JOY_DATA   = data_q;
    assign frame_done = done_q;
    assign bit_idx    = bidx_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx with FILT=3, TMO=100; expected wire patterns are hand-computed constants.
module tb_joy_db15_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] joystick1, joystick2;
    logic        JOY_CLK, JOY_LOAD;
    logic        JOY_DATA, frame_done;
    logic [4:0]  bit_idx;

    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt = 0;

    joy_db15_tx #(.FILT(3), .TMO(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        JOY_CLK = 1'b1;
        repeat (8) tick();
        JOY_CLK = 1'b0;
        repeat (8) tick();
    endtask

    task automatic load_seq(input logic [23:0] pat);
        JOY_LOAD = 1'b0;
        repeat (10) tick();
        check_val("load_idx", 32'(bit_idx), 32'd0);
        check_val("load_data", 32'(JOY_DATA), 32'(pat[0]));
        JOY_LOAD = 1'b1;
        repeat (10) tick();
    endtask

    task automatic shift_bits(input logic [23:0] pat, input int from, input int to);
        for (int i = from; i < to; i++) begin
            check_val("shift_data", 32'(JOY_DATA), (i < 24) ? 32'(pat[i]) : 32'd1);
            check_val("shift_idx", 32'(bit_idx), (i < 24) ? 32'(i) : 32'd24);
            pulse();
        end
    endtask

    initial begin
        logic [23:0] pat_a, pat_b;
        pat_a = 24'h7FFFFE;   // j1=001, j2=800
        pat_b = 24'hC3E5A2;   // j1=A5D, j2=3C1

        reset = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        JOY_CLK = 1'b0;
        JOY_LOAD = 1'b1;
        repeat (3) tick();
        check_val("rst_data", 32'(JOY_DATA), 32'd1);
        check_val("rst_idx", 32'(bit_idx), 32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        check_val("idle_data", 32'(JOY_DATA), 32'd1);
        check_val("idle_idx", 32'(bit_idx), 32'd0);

        // Full frame, first edge timed exactly.
        joystick1 = 12'h001;
        joystick2 = 12'h800;
        load_seq(pat_a);
        JOY_CLK = 1'b1;
        repeat (5) tick();
        check_val("lat5_data", 32'(JOY_DATA), 32'd0);
        check_val("lat5_idx", 32'(bit_idx), 32'd0);
        tick();
        check_val("lat6_data", 32'(JOY_DATA), 32'd1);
        check_val("lat6_idx", 32'(bit_idx), 32'd1);
        repeat (2) tick();
        JOY_CLK = 1'b0;
        repeat (8) tick();
        shift_bits(pat_a, 1, 24);
        check_val("f1_idx", 32'(bit_idx), 32'd24);
        check_val("f1_data", 32'(JOY_DATA), 32'd1);
        check_val("f1_done", 32'(fd_cnt), 32'd1);
        pulse();
        pulse();
        check_val("done_hold_idx", 32'(bit_idx), 32'd24);
        check_val("done_hold_cnt", 32'(fd_cnt), 32'd1);

        // Glitch rejection, then abort with coincident clock edge.
        joystick1 = 12'hA5D;
        joystick2 = 12'h3C1;
        load_seq(pat_b);
        shift_bits(pat_b, 0, 5);
        JOY_CLK = 1'b1;
        repeat (2) tick();
        JOY_CLK = 1'b0;
        repeat (12) tick();
        check_val("glitch_idx", 32'(bit_idx), 32'd5);
        check_val("glitch_data", 32'(JOY_DATA), 32'd1);
        shift_bits(pat_b, 5, 10);
        check_val("pre_abort_idx", 32'(bit_idx), 32'd10);
        JOY_LOAD = 1'b0;
        JOY_CLK = 1'b1;
        repeat (10) tick();
        check_val("abort_idx", 32'(bit_idx), 32'd0);
        check_val("abort_data", 32'(JOY_DATA), 32'd0);
        check_val("abort_done", 32'(fd_cnt), 32'd1);
        JOY_CLK = 1'b0;
        repeat (10) tick();
        check_val("load_clk_ign", 32'(bit_idx), 32'd0);
        load_seq(pat_b);
        shift_bits(pat_b, 0, 24);
        check_val("f2_idx", 32'(bit_idx), 32'd24);
        check_val("f2_done", 32'(fd_cnt), 32'd2);

        // Over-clocked frame saturates.
        load_seq(pat_b);
        shift_bits(pat_b, 0, 30);
        check_val("sat_idx", 32'(bit_idx), 32'd24);
        check_val("sat_data", 32'(JOY_DATA), 32'd1);
        check_val("sat_done", 32'(fd_cnt), 32'd3);

        // Timeout back to IDLE.
        load_seq(pat_b);
        shift_bits(pat_b, 0, 5);
        repeat (80) tick();
        check_val("tmo_pre_idx", 32'(bit_idx), 32'd5);
        repeat (40) tick();
        check_val("tmo_idx", 32'(bit_idx), 32'd0);
        check_val("tmo_data", 32'(JOY_DATA), 32'd1);
        check_val("tmo_done", 32'(fd_cnt), 32'd3);
        pulse();
        check_val("idle_clk_ign", 32'(bit_idx), 32'd0);

        // Reset mid-frame.
        load_seq(pat_b);
        shift_bits(pat_b, 0, 12);
        check_val("pre_rst_idx", 32'(bit_idx), 32'd12);
        check_val("pre_rst_data", 32'(JOY_DATA), 32'd0);
        reset = 1'b1;
        tick();
        check_val("mid_rst_data", 32'(JOY_DATA), 32'd1);
        check_val("mid_rst_idx", 32'(bit_idx), 32'd0);
        check_val("mid_rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        check_val("post_rst_cnt", 32'(fd_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
